// File: rtl/axi_line_master.sv
// AXI4 line master: turns one-shot cache-line refill/writeback requests into
// single INCR bursts of 32-bit beats, with one transaction outstanding at a time.
module axi_line_master #(
    parameter int LINE_WORDS = 4
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [31:0]              req_addr,
    input  logic [LINE_WORDS*32-1:0] req_wdata,

    output logic                     resp_valid,
    output logic [LINE_WORDS*32-1:0] resp_rdata,
    output logic                     resp_err,

    input  logic                     out_awready,
    output logic                     out_awvalid,
    output logic [31:0]              out_awaddr,
    output logic [7:0]               out_awlen,

    input  logic                     out_wready,
    output logic                     out_wvalid,
    output logic [31:0]              out_wdata,
    output logic                     out_wlast,

    output logic                     out_bready,
    input  logic                     out_bvalid,
    input  logic [1:0]               out_bresp,

    input  logic                     out_arready,
    output logic                     out_arvalid,
    output logic [31:0]              out_araddr,
    output logic [7:0]               out_arlen,

    output logic                     out_rready,
    input  logic                     out_rvalid,
    input  logic [1:0]               out_rresp,
    input  logic [31:0]              out_rdata,
    input  logic                     out_rlast
);

    localparam int              LINE_W    = LINE_WORDS * 32;
    localparam int              CNT_W     = $clog2(LINE_WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] BEAT_END  = CNT_W'(LINE_WORDS);
    localparam logic [7:0]       BURST_LEN = 8'(LINE_WORDS - 1);
    localparam logic [31:0]      ADDR_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic [LINE_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   beat_q, beat_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            beat_q  <= beat_d;
        end
    end

    assign resp_rdata = rdata_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        beat_d      = beat_q;

        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;
        out_awvalid = 1'b0;
        out_awaddr  = '0;
        out_awlen   = '0;
        out_wvalid  = 1'b0;
        out_wdata   = '0;
        out_wlast   = 1'b0;
        out_bready  = 1'b0;
        out_arvalid = 1'b0;
        out_araddr  = '0;
        out_arlen   = '0;
        out_rready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr & ADDR_MASK;
                    wdata_d = req_wdata;
                    err_d   = 1'b0;
                    beat_d  = '0;
                    state_d = req_write ? S_AW : S_AR;
                end
            end

            S_AR: begin
                out_arvalid = 1'b1;
                out_araddr  = addr_q;
                out_arlen   = BURST_LEN;
                if (out_arready) begin
                    state_d = S_R;
                end
            end

            // Beats past the end of the line are still drained until rlast,
            // but beat_q parks at BEAT_END so they are never stored.
            S_R: begin
                out_rready = 1'b1;
                if (out_rvalid) begin
                    if (beat_q != BEAT_END) begin
                        for (int i = 0; i < LINE_WORDS; i++) begin
                            if (beat_q == CNT_W'(i)) begin
                                rdata_d[i*32 +: 32] = out_rdata;
                            end
                        end
                        beat_d = beat_q + CNT_W'(1);
                    end
                    if (out_rresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (out_rlast) begin
                        if (beat_q != LAST_BEAT) begin
                            err_d = 1'b1;
                        end
                        state_d = S_RESP;
                    end else if (beat_q == LAST_BEAT) begin
                        err_d = 1'b1;
                    end
                end
            end

            S_AW: begin
                out_awvalid = 1'b1;
                out_awaddr  = addr_q;
                out_awlen   = BURST_LEN;
                if (out_awready) begin
                    state_d = S_W;
                end
            end

            S_W: begin
                out_wvalid = 1'b1;
                out_wlast  = (beat_q == LAST_BEAT);
                for (int i = 0; i < LINE_WORDS; i++) begin
                    if (beat_q == CNT_W'(i)) begin
                        out_wdata = wdata_q[i*32 +: 32];
                    end
                end
                if (out_wready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_B;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end

            S_B: begin
                out_bready = 1'b1;
                if (out_bvalid) begin
                    if (out_bresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_line_master.sv
// Self-checking bench for axi_line_master: a behavioural AXI slave plus a
// line-level reference model, driven by directed and randomized transactions.
module tb_axi_line_master;

   localparam int LW        = 4;
   localparam int LINE_BITS = LW * 32;

   logic                 clock;
   logic                 reset;
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [31:0]          req_addr;
   logic [LINE_BITS-1:0] req_wdata;
   logic                 resp_valid;
   logic [LINE_BITS-1:0] resp_rdata;
   logic                 resp_err;
   logic                 out_awready;
   logic                 out_awvalid;
   logic [31:0]          out_awaddr;
   logic [7:0]           out_awlen;
   logic                 out_wready;
   logic                 out_wvalid;
   logic [31:0]          out_wdata;
   logic                 out_wlast;
   logic                 out_bready;
   logic                 out_bvalid;
   logic [1:0]           out_bresp;
   logic                 out_arready;
   logic                 out_arvalid;
   logic [31:0]          out_araddr;
   logic [7:0]           out_arlen;
   logic                 out_rready;
   logic                 out_rvalid;
   logic [1:0]           out_rresp;
   logic [31:0]          out_rdata;
   logic                 out_rlast;

   int                   vectors;
   int                   miscompares;
   int                   cycle;
   int                   accepts;
   int                   acceptCycle;
   logic [LINE_BITS-1:0] expRdata;

   axi_line_master #(.LINE_WORDS(LW)) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .out_awready (out_awready),
      .out_awvalid (out_awvalid),
      .out_awaddr  (out_awaddr),
      .out_awlen   (out_awlen),
      .out_wready  (out_wready),
      .out_wvalid  (out_wvalid),
      .out_wdata   (out_wdata),
      .out_wlast   (out_wlast),
      .out_bready  (out_bready),
      .out_bvalid  (out_bvalid),
      .out_bresp   (out_bresp),
      .out_arready (out_arready),
      .out_arvalid (out_arvalid),
      .out_araddr  (out_araddr),
      .out_arlen   (out_arlen),
      .out_rready  (out_rready),
      .out_rvalid  (out_rvalid),
      .out_rresp   (out_rresp),
      .out_rdata   (out_rdata),
      .out_rlast   (out_rlast)
   );

   // Free-running clock, 10 time units per cycle
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports any miscompare
   task automatic checkOutput(input string tag, input logic [LINE_BITS-1:0] got,
                              input logic [LINE_BITS-1:0] expected);
      vectors++;
      if (got !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expected);
      end
   endtask

   // Advance one cycle; a request handshake is recorded when valid and ready
   // are both high going into the rising edge
   task automatic step();
      if (req_valid && req_ready && !reset) begin
         accepts++;
         acceptCycle = cycle;
      end
      @(posedge clock);
      cycle++;
      @(negedge clock);
   endtask

   // Everything the block exposes after reset: idle, no bus activity, no data
   task automatic checkResetState(input string tag);
      checkOutput({tag, "_valids"},
                  {out_awvalid, out_wvalid, out_wlast, out_bready, out_arvalid,
                   out_rready, resp_valid, resp_err}, 0);
      checkOutput({tag, "_addr"}, {out_awaddr, out_araddr}, 0);
      checkOutput({tag, "_len"}, {out_awlen, out_arlen}, 0);
      checkOutput({tag, "_rdata"}, resp_rdata, 0);
      checkOutput({tag, "_req_ready"}, req_ready, 1);
   endtask

   function automatic logic [LINE_BITS-1:0] randomLine();
      logic [LINE_BITS-1:0] r;
      for (int i = 0; i < LW; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // One full transaction: issue the request, play the slave side, and
   // compare the completion against the line-level model
   task automatic applyStimulus(
      input logic                 wr,
      input logic [31:0]          addr,
      input logic [LINE_BITS-1:0] wdata,
      input logic [LINE_BITS-1:0] rdata,
      input int                   nBeats,
      input int                   errBeat,
      input logic [1:0]           errResp,
      input logic [1:0]           bresp,
      input int                   addrDelay,
      input int                   wStall,
      input bit                   holdReq,
      input bit                   gaps,
      input int                   resetBeat,
      input int                   expLatency);
      int                   acc0;
      int                   addrWait;
      int                   addrHs;
      int                   beat;
      int                   stall;
      int                   bHs;
      bit                   done;
      logic                 expErr;
      logic [31:0]          expAddr;
      logic [31:0]          expWord;
      logic [LINE_BITS-1:0] newRdata;

      expAddr  = addr - (addr % 32'(LW * 4));
      newRdata = expRdata;
      if (wr) begin
         expErr = (bresp != 2'b00);
      end else begin
         expErr = (nBeats != LW) || (errBeat >= 0 && errBeat < nBeats && errResp != 2'b00);
         for (int i = 0; i < LW && i < nBeats; i++) newRdata[i*32 +: 32] = rdata[i*32 +: 32];
      end

      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      acc0      = accepts;
      for (int i = 0; i < 50 && accepts == acc0; i++) step();
      if (accepts == acc0) begin
         checkOutput("accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      if (!holdReq) begin
         req_valid = 1'b0;
         req_write = ~wr;
         req_addr  = $urandom;
         req_wdata = randomLine();
      end

      done     = 1'b0;
      addrWait = 0;
      addrHs   = 0;
      beat     = 0;
      stall    = 0;
      bHs      = 0;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         out_arready = 1'b0;
         out_awready = 1'b0;
         out_wready  = 1'b0;
         out_bvalid  = 1'b0;
         out_bresp   = 2'b00;
         out_rvalid  = 1'b0;
         out_rresp   = 2'b00;
         out_rdata   = 32'h0;
         out_rlast   = 1'b0;
         if (holdReq) checkOutput("req_ready_busy", req_ready, 0);

         if (resp_valid) begin
            done = 1'b1;
            checkOutput("resp_err", resp_err, expErr);
            checkOutput("resp_rdata", resp_rdata, newRdata);
            checkOutput("addr_handshakes", addrHs, 1);
            if (wr) begin
               checkOutput("w_beats", beat, LW);
               checkOutput("b_handshakes", bHs, 1);
            end else begin
               checkOutput("r_beats", beat, nBeats);
            end
            // Latency counts the accept cycle and the resp_valid cycle inclusively
            if (expLatency > 0) checkOutput("latency", cycle - acceptCycle + 1, expLatency);
            if (holdReq) begin
               checkOutput("held_accepts", accepts - acc0, 1);
               req_valid = 1'b0;
            end
            expRdata = newRdata;
            step();
            checkOutput("resp_pulse", resp_valid, 0);
         end else if (out_arvalid) begin
            checkOutput("ar_on_write", wr, 0);
            checkOutput("araddr", out_araddr, expAddr);
            checkOutput("arlen", out_arlen, LW - 1);
            if (addrWait >= addrDelay) begin
               out_arready = 1'b1;
               addrHs++;
            end
            addrWait++;
         end else if (out_awvalid) begin
            checkOutput("aw_on_read", wr, 1);
            checkOutput("w_before_aw", out_wvalid, 0);
            checkOutput("awaddr", out_awaddr, expAddr);
            checkOutput("awlen", out_awlen, LW - 1);
            if (addrWait >= addrDelay) begin
               out_awready = 1'b1;
               addrHs++;
            end
            addrWait++;
         end else if (out_rready) begin
            if (!gaps || $urandom_range(0, 2) != 0) begin
               out_rvalid = 1'b1;
               if (beat < LW) out_rdata = rdata[beat*32 +: 32];
               else           out_rdata = $urandom;
               out_rresp = (beat == errBeat) ? errResp : 2'b00;
               out_rlast = (beat == nBeats - 1);
               beat++;
            end
         end else if (out_wvalid) begin
            checkOutput("w_after_aw", addrHs, 1);
            checkOutput("w_beat_range", beat < LW, 1);
            expWord = 32'h0;
            if (beat < LW) expWord = wdata[beat*32 +: 32];
            checkOutput("wdata", out_wdata, expWord);
            checkOutput("wlast", out_wlast, beat == LW - 1);
            if (beat == resetBeat) begin
               #1 reset = 1'b1;
               #1 checkResetState("reset_mid_w");
               expRdata = '0;
               done     = 1'b1;
               step();
               reset = 1'b0;
            end else if (stall < wStall) begin
               stall++;
            end else begin
               out_wready = 1'b1;
               stall      = 0;
               beat++;
            end
         end else if (out_bready) begin
            if (!gaps || $urandom_range(0, 1) != 0) begin
               out_bvalid = 1'b1;
               out_bresp  = bresp;
               bHs++;
            end
         end

         if (!done) step();
      end
      if (!done) checkOutput("resp_timeout", 0, 1);
   endtask

   initial begin
      logic [LINE_BITS-1:0] refillLine;
      logic [LINE_BITS-1:0] wbLine;
      logic                 wr;
      int                   nBeats;
      int                   errBeat;

      vectors     = 0;
      miscompares = 0;
      cycle       = 0;
      accepts     = 0;
      acceptCycle = 0;
      expRdata    = '0;
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_addr    = 32'h0;
      req_wdata   = '0;
      out_awready = 1'b0;
      out_wready  = 1'b0;
      out_bvalid  = 1'b0;
      out_bresp   = 2'b00;
      out_arready = 1'b0;
      out_rvalid  = 1'b0;
      out_rresp   = 2'b00;
      out_rdata   = 32'h0;
      out_rlast   = 1'b0;

      #2 checkResetState("reset_init");
      @(negedge clock);
      reset = 1'b0;

      $display("[TB] directed refill and writeback");
      refillLine = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      wbLine     = {32'h000000A3, 32'h000000A2, 32'h000000A1, 32'h000000A0};
      applyStimulus(1'b0, 32'ha0000014, '0, refillLine, 4, -1, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0, -1, 3 + LW);
      checkOutput("refill_line", resp_rdata, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
      applyStimulus(1'b1, 32'h80001000, wbLine, '0, 4, -1, 2'b00, 2'b00, 0, 2, 1'b0, 1'b0, -1, 0);

      $display("[TB] error responses");
      applyStimulus(1'b1, 32'h80002040, randomLine(), '0, 4, -1, 2'b00, 2'b10, 1, 0, 1'b0, 1'b0, -1, 0);
      applyStimulus(1'b0, 32'h40000100, '0, randomLine(), 4, 1, 2'b11, 2'b00, 0, 0, 1'b0, 1'b0, -1, 0);
      applyStimulus(1'b0, 32'h40000200, '0, randomLine(), 3, -1, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0, -1, 0);
      applyStimulus(1'b0, 32'h40000300, '0, randomLine(), 6, -1, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0, -1, 0);

      $display("[TB] AR backpressure with held request");
      applyStimulus(1'b0, 32'h12345678, '0, randomLine(), 4, -1, 2'b00, 2'b00, 5, 0, 1'b1, 1'b0, -1, 0);

      $display("[TB] reset during write beat 2, then a clean read");
      applyStimulus(1'b1, 32'h80003000, randomLine(), '0, 4, -1, 2'b00, 2'b00, 0, 1, 1'b0, 1'b0, 2, 0);
      applyStimulus(1'b0, 32'h80003000, '0, randomLine(), 4, -1, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0, -1, 3 + LW);

      $display("[TB] back-to-back read, write, read");
      applyStimulus(1'b0, 32'h00000040, '0, randomLine(), 4, -1, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0, -1, 3 + LW);
      applyStimulus(1'b1, 32'h00000080, randomLine(), '0, 4, -1, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0, -1, 0);
      applyStimulus(1'b0, 32'h000000c0, '0, randomLine(), 4, -1, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0, -1, 3 + LW);

      $display("[TB] randomized transactions");
      for (int t = 0; t < 40; t++) begin
         wr      = 1'($urandom_range(0, 1));
         nBeats  = ($urandom_range(0, 5) < 4) ? LW : int'($urandom_range(1, LW + 2));
         errBeat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
         applyStimulus(wr, $urandom, randomLine(), randomLine(), nBeats, errBeat,
                       2'($urandom_range(1, 3)),
                       ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                       1'b0, 1'($urandom_range(0, 1)), -1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
